// File: rtl/serial_pkg.sv
// Shared types and constants for the serial transmit path.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Minimum width of 1 so single-value counters still get a real register.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < v) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/serial_tx_framer_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, tick on the last count.
module bit_timer
  import serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W = clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clr || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/serial_tx_framer.sv
// Parallel-to-serial framer: start, N data bits LSB first, [parity], stop.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit after the data.
module serial_tx_framer
  import serial_pkg::*;
#(
  parameter int unsigned N            = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         tx,
  output logic         busy,
  output logic         tx_done
);

  localparam int unsigned IW = clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_t        r_state;
  logic [N-1:0]  r_shreg;
  logic [IW-1:0] r_idx;
  logic          r_tx;
  logic          r_ready;
  logic          r_busy;
`ifdef SERIAL_TX_PARITY_EN
  logic          r_par;
`endif

  logic w_tick;
  logic w_clr;
  logic w_xfer;

  assign w_clr  = (r_state == IDLE);
  assign w_xfer = in_valid && r_ready;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (w_clr),
    .tick   (w_tick)
  );

  // tx is loaded one bit ahead so the line changes exactly on bit boundaries.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_idx   <= '0;
      r_tx    <= IDLE_LEVEL;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_shreg <= in_data;
`ifdef SERIAL_TX_PARITY_EN
            r_par   <= ^in_data;
`endif
            r_tx    <= START_BIT;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= START;
          end
        end
        START: begin
          if (w_tick) begin
            r_tx    <= r_shreg[0];
            r_idx   <= '0;
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_idx == LAST_IDX) begin
`ifdef SERIAL_TX_PARITY_EN
              r_tx    <= r_par;
              r_state <= PARITY;
`else
              r_tx    <= STOP_BIT;
              r_state <= STOP;
`endif
            end else begin
              r_shreg <= {1'b0, r_shreg[N-1:1]};
              r_tx    <= r_shreg[1];
              r_idx   <= r_idx + 1'b1;
            end
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        PARITY: begin
          if (w_tick) begin
            r_tx    <= STOP_BIT;
            r_state <= STOP;
          end
        end
`endif
        STOP: begin
          if (w_tick) begin
            r_tx    <= IDLE_LEVEL;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_tx    <= IDLE_LEVEL;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready = r_ready;
  assign tx       = r_tx;
  assign busy     = r_busy;
  assign tx_done  = (r_state == STOP) && w_tick;

endmodule

// File: tb/tb_serial_tx_framer.sv
// Randomized self-checking bench for serial_tx_framer (N=8, CLKS_PER_BIT=4).
module tb_serial_tx_framer;

  localparam int unsigned N   = 8;
  localparam int unsigned CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int unsigned PAR = 1;
`else
  localparam int unsigned PAR = 0;
`endif
  localparam int unsigned NBITS = N + 2 + PAR;
  localparam int unsigned FL    = NBITS * CPB;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         tx;
  logic         busy;
  logic         tx_done;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned cyc         = 0;
  int unsigned start_cyc   = 0;
  int unsigned start_prev  = 0;
  int          inj_at      = -1;
  logic [N-1:0] inj_data   = '0;
  logic         keep_valid = 1'b0;
  logic [N-1:0] keep_data  = '0;

  serial_tx_framer #(
    .N(N),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .tx      (tx),
    .busy    (busy),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Line level expected during bit slot b of a frame carrying w.
  function automatic logic exp_bit(input logic [N-1:0] w, input int unsigned b);
    if (b == 0) return 1'b0;
    if (b <= N) return w[b-1];
    if (PAR == 1 && b == N + 1) return ^w;
    return 1'b1;
  endfunction

  task automatic xfer(input logic [N-1:0] w);
    int unsigned n;
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("xfer_ready", {31'd0, in_ready}, 32'd1);
    in_data  = w;
    in_valid = 1'b1;
    @(posedge clk);
  endtask

  // Called just after the transfer edge; ends on the first idle cycle.
  task automatic frame_check(input logic [N-1:0] w);
    int unsigned lows;
    int unsigned exp_lows;
    lows = 0;
    exp_lows = 0;
    for (int b = 0; b < int'(NBITS); b++)
      if (exp_bit(w, b) == 1'b0) exp_lows += CPB;
    for (int j = 0; j < int'(FL); j++) begin
      @(negedge clk);
      if (j == 0) begin
        start_prev = start_cyc;
        start_cyc  = cyc;
        in_valid   = keep_valid;
        in_data    = keep_data;
      end
      if (j == inj_at) begin
        in_valid = 1'b1;
        in_data  = inj_data;
      end
      if (j == inj_at + 1) in_valid = 1'b0;
      check("tx", {31'd0, tx}, {31'd0, exp_bit(w, j / CPB)});
      check("busy", {31'd0, busy}, 32'd1);
      check("in_ready", {31'd0, in_ready}, 32'd0);
      check("tx_done", {31'd0, tx_done}, (j == int'(FL) - 1) ? 32'd1 : 32'd0);
      if (tx === 1'b0) lows++;
    end
    @(negedge clk);
    check("idle_tx", {31'd0, tx}, 32'd1);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_ready", {31'd0, in_ready}, 32'd1);
    check("idle_done", {31'd0, tx_done}, 32'd0);
    check("low_cycles", lows, exp_lows);
  endtask

  initial begin
    logic [N-1:0] w;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, tx_done}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    xfer(8'hA5);
    frame_check(8'hA5);

    keep_valid = 1'b1;
    keep_data  = 8'hFF;
    xfer(8'h00);
    frame_check(8'h00);
    keep_valid = 1'b0;
    keep_data  = '0;
    xfer(8'hFF);
    frame_check(8'hFF);
    check("b2b_gap", start_cyc - start_prev, FL + 1);

    inj_at   = 10;
    inj_data = 8'h3C;
    xfer(8'h81);
    frame_check(8'h81);
    inj_at = -1;
    for (int i = 0; i < int'(FL) + 8; i++) begin
      @(negedge clk);
      check("no_2nd_tx", {31'd0, tx}, 32'd1);
      check("no_2nd_busy", {31'd0, busy}, 32'd0);
    end

    xfer(8'h55);
    for (int j = 0; j < 14; j++) @(negedge clk);
    check("mid_tx", {31'd0, tx}, {31'd0, exp_bit(8'h55, 3)});
    check("mid_busy", {31'd0, busy}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_tx", {31'd0, tx}, 32'd1);
    check("async_busy", {31'd0, busy}, 32'd0);
    check("async_ready", {31'd0, in_ready}, 32'd1);
    check("async_done", {31'd0, tx_done}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_tx", {31'd0, tx}, 32'd1);
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);
    xfer(8'h0F);
    frame_check(8'h0F);

    xfer(8'h07);
    frame_check(8'h07);

    for (int r = 0; r < 8; r++) begin
      w = N'($urandom);
      keep_data = N'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      xfer(w);
      frame_check(w);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
